axi_wr_queue: RTL and testbench

AXI_WR_QUEUE -- requirements
Module: axi_wr_queue

---
 rtl/axi_wr_queue_pkg.sv | 19 +
 rtl/axi_wr_queue_wr_entry_ram.sv | 31 +++
 rtl/axi_wr_queue.sv | 136 +++++++++++++
 tb/tb_axi_wr_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_queue_pkg.sv
// rtl/axi_wr_queue_pkg.sv - shared AXI constants and write-entry type for axi_wr_queue
// Contents: BURST_INCR, RESP_* codes, LEN_SINGLE, wr_entry_t {addr, size, wstrb, wdata}.
package axi_wr_queue_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wr_entry_t;

endpackage

// File: rtl/axi_wr_queue_wr_entry_ram.sv
// rtl/axi_wr_queue_wr_entry_ram.sv - DEPTH-entry register file, one write port, two async read ports
// Ports: clk; we/waddr/wentry write port; aw_raddr/aw_rentry and w_raddr/w_rentry read ports.
// Storage is intentionally not reset: consumers qualify every read with a valid.
module wr_entry_ram
    import axi_wr_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  wr_entry_t     wentry,
    input  logic [IW-1:0] aw_raddr,
    output wr_entry_t     aw_rentry,
    input  logic [IW-1:0] w_raddr,
    output wr_entry_t     w_rentry
);

    wr_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign aw_rentry = mem[aw_raddr];
    assign w_rentry  = mem[w_raddr];

endmodule

// File: rtl/axi_wr_queue.sv
// rtl/axi_wr_queue.sv - queues SRAM-style writes and issues them as single-beat AXI writes
// Ports: clk, reset (async, active-high); SRAM side data_sram_* (req/wr/size/wstrb/addr/wdata in,
// addr_ok/data_ok out); AXI AW (awid..awvalid, awready), W (wid..wvalid, wready), B (bid, bresp,
// bvalid in, bready out). Macro AXI_WR_QUEUE_BRESP_ERR_EN adds sticky output wr_err.
module axi_wr_queue
    import axi_wr_queue_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
    output logic        wr_err,
`endif
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Pointers carry a wrap bit so that full and empty are distinguishable.
    logic [PW-1:0] wr_ptr, aw_ptr, w_ptr, b_ptr;
    logic [PW-1:0] occupancy;
    logic          full;
    logic          push, aw_hs, w_hs, b_hs;
    logic          data_ok_q;
    wr_entry_t     new_entry, aw_entry, w_entry;

    assign occupancy = wr_ptr - b_ptr;
    // full comes only from registered pointers, so a B handshake cannot open a slot in the same cycle.
    assign full      = (occupancy == PW'(DEPTH));
    assign push      = data_sram_req & data_sram_wr & ~full & ~reset;

    assign awvalid   = (aw_ptr != wr_ptr);
    assign wvalid    = (w_ptr != wr_ptr);
    // A response may only be taken for an entry whose address and data have both been sent.
    assign bready    = (b_ptr != aw_ptr) && (b_ptr != w_ptr);

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;

    assign new_entry = '{addr: data_sram_addr, size: data_sram_size,
                         wstrb: data_sram_wstrb, wdata: data_sram_wdata};

    wr_entry_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk      (clk),
        .we       (push),
        .waddr    (wr_ptr[IW-1:0]),
        .wentry   (new_entry),
        .aw_raddr (aw_ptr[IW-1:0]),
        .aw_rentry(aw_entry),
        .w_raddr  (w_ptr[IW-1:0]),
        .w_rentry (w_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            aw_ptr    <= '0;
            w_ptr     <= '0;
            b_ptr     <= '0;
            data_ok_q <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PW'(1);
            if (aw_hs) aw_ptr <= aw_ptr + PW'(1);
            if (w_hs)  w_ptr  <= w_ptr + PW'(1);
            if (b_hs)  b_ptr  <= b_ptr + PW'(1);
            data_ok_q <= b_hs;
        end
    end

`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else if (b_hs && (bresp != RESP_OKAY)) begin
            wr_err <= 1'b1;
        end
    end
    logic unused_bid;
    assign unused_bid = ^bid;
`else
    logic unused_b;
    assign unused_b = ^{bid, bresp};
`endif

    assign data_sram_addr_ok = push;
    assign data_sram_data_ok = data_ok_q;

    assign awid    = AXI_ID;
    assign awaddr  = aw_entry.addr;
    assign awlen   = LEN_SINGLE;
    assign awsize  = {1'b0, aw_entry.size};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = AXI_ID;
    assign wdata   = w_entry.wdata;
    assign wstrb   = w_entry.wstrb;
    assign wlast   = 1'b1;

    logic unused_fields;
    assign unused_fields = ^{aw_entry.wstrb, aw_entry.wdata, w_entry.addr, w_entry.size};

endmodule

// File: tb/tb_axi_wr_queue.sv
// tb/tb_axi_wr_queue.sv - directed scoreboard bench for axi_wr_queue
module tb_axi_wr_queue;
    import axi_wr_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
    logic        wr_err;
    logic        exp_err;
`endif

    always #5 clk = ~clk;

    axi_wr_queue #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
        .wr_err(wr_err),
`endif
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int total = 0;
    int bad = 0;
    int n_push, n_aw, n_w, n_b, n_dok, occ_max;
    bit exp_dok, last_acc;
    wr_entry_t aw_q[$];
    wr_entry_t w_q[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        n_push = 0; n_aw = 0; n_w = 0; n_b = 0;
        exp_dok = 1'b0;
        aw_q.delete();
        w_q.delete();
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
        exp_err = 1'b0;
`endif
    endtask

    // Samples at the falling edge, checks against the model, then returns 1 time unit after the rising edge.
    task automatic step();
        wr_entry_t e;
        bit b_hs;
        bit exp_aok;
        @(negedge clk);
        chk("awvalid", awvalid, n_aw != n_push);
        chk("wvalid", wvalid, n_w != n_push);
        chk("bready", bready, (n_b != n_aw) && (n_b != n_w));
        exp_aok = data_sram_req && data_sram_wr && ((n_push - n_b) < DEPTH) && !reset;
        chk("addr_ok", data_sram_addr_ok, exp_aok);
        chk("data_ok", data_sram_data_ok, exp_dok);
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
        chk("wr_err", wr_err, exp_err);
`endif
        if (data_sram_data_ok) n_dok++;
        if (awvalid && awready) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
                e = aw_q.pop_front();
                chk("awaddr", awaddr, e.addr);
                chk("awsize", awsize, {1'b0, e.size});
                chk("awid", awid, 4'd1);
                chk("aw_consts", {awlen, awburst, awlock, awcache, awprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            end
            n_aw++;
        end
        if (wvalid && wready) begin
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else begin
                e = w_q.pop_front();
                chk("wdata", wdata, e.wdata);
                chk("wstrb", wstrb, e.wstrb);
                chk("wlast_wid", {wlast, wid}, {1'b1, 4'd1});
            end
            n_w++;
        end
        b_hs = bvalid && bready;
`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
        if (b_hs && bresp != 2'b00) exp_err = 1'b1;
`endif
        if (b_hs) n_b++;
        exp_dok = b_hs;
        last_acc = data_sram_addr_ok;
        if (data_sram_addr_ok) begin
            e = '{addr: data_sram_addr, size: data_sram_size, wstrb: data_sram_wstrb, wdata: data_sram_wdata};
            aw_q.push_back(e);
            w_q.push_back(e);
            n_push++;
        end
        if (n_push - n_b > occ_max) occ_max = n_push - n_b;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [1:0] sz);
        data_sram_req = 1'b1; data_sram_wr = 1'b1;
        data_sram_addr = a; data_sram_wdata = d; data_sram_wstrb = s; data_sram_size = sz;
    endtask

    task automatic push(logic [31:0] a, logic [31:0] d);
        int n;
        set_req(a, d, 4'hF, 2'd2);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("push_timeout", 0, 1);
        data_sram_req = 1'b0;
    endtask

    int acc, dok0;

    initial begin
        reset = 1'b1;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        awready = 0; wready = 0; bid = 4'd1; bresp = 2'b00; bvalid = 0;
        occ_max = 0; n_dok = 0; last_acc = 0;
        flush_model();

        // Reset state, including a write request that must be refused.
        #2;
        set_req(32'h1000, 32'h0, 4'hF, 2'd2);
        #1;
        chk("rst_outputs", {awvalid, wvalid, bready, data_sram_addr_ok, data_sram_data_ok}, 5'b0);
        data_sram_req = 0;
        step();
        reset = 1'b0;
        step();

        // Single write, B two cycles after W.
        awready = 1; wready = 1;
        push(32'h1000, 32'hDEADBEEF);
        step();
        chk("single_awdone", n_aw, 1);
        step(); step();
        bvalid = 1;
        step();
        bvalid = 0;
        step();
        chk("single_dok", n_dok, 1);

        // Non-write requests are ignored.
        data_sram_req = 1; data_sram_wr = 0;
        step();
        data_sram_req = 0;
        chk("rd_ignored", n_push, 1);

        // Fill to DEPTH with stalled channels, 5th waits for the first response.
        awready = 0; wready = 0;
        acc = 0;
        set_req(32'h2000, 32'h1111_0000, 4'h3, 2'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_acc) begin
                acc++;
                set_req(32'h2000 + acc * 4, 32'h1111_0000 + acc, 4'h3, 2'd1);
            end
        end
        chk("fill_count", acc, 4);
        awready = 1; wready = 1; bvalid = 1;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        chk("fifth_accepted", last_acc, 1);
        data_sram_req = 0;
        repeat (8) step();
        bvalid = 0;
        chk("fill_drained", n_b, n_push);

        // Skewed channels: W runs ahead, bvalid held high.
        awready = 0; wready = 1; bvalid = 1;
        dok0 = n_dok;
        push(32'h3000, 32'hA0A0_0001);
        push(32'h3004, 32'hA0A0_0002);
        push(32'h3008, 32'hA0A0_0003);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            awready = 1;
            step();
            awready = 0;
            repeat (3) step();
        end
        repeat (2) step();
        bvalid = 0;
        chk("skew_dok", n_dok - dok0, 3);

        // Full queue, B handshake and new request in the same cycle.
        awready = 1; wready = 1; bvalid = 0;
        for (int i = 0; i < 4; i++) push(32'h4000 + i * 4, 32'hB0B0_0000 + i);
        repeat (2) step();
        set_req(32'h4010, 32'hB0B0_0004, 4'hF, 2'd2);
        bvalid = 1;
        step();
        chk("full_same_cycle", last_acc, 0);
        bvalid = 0;
        step();
        chk("full_next_cycle", last_acc, 1);
        data_sram_req = 0;
        bvalid = 1;
        repeat (8) step();
        bvalid = 0;
        chk("occ_max", occ_max <= DEPTH, 1);

        // Reset with two writes outstanding.
        awready = 0; wready = 0; bvalid = 1;
        push(32'h5000, 32'hC0C0_0001);
        push(32'h5004, 32'hC0C0_0002);
        awready = 1; wready = 1;
        set_req(32'h5008, 32'h0, 4'hF, 2'd2);
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {awvalid, wvalid, bready, data_sram_addr_ok, data_sram_data_ok}, 5'b0);
        flush_model();
        data_sram_req = 0;
        step(); step();
        reset = 1'b0;
        dok0 = n_dok;
        repeat (3) step();
        chk("midrst_no_dok", n_dok - dok0, 0);
        push(32'h6000, 32'h0123_4567);
        repeat (4) step();
        bvalid = 0;
        chk("after_rst_dok", n_dok - dok0, 1);

`ifdef AXI_WR_QUEUE_BRESP_ERR_EN
        // Error response on the 2nd of 3 writes.
        dok0 = n_dok;
        push(32'h7000, 32'h7);
        push(32'h7004, 32'h8);
        push(32'h7008, 32'h9);
        step();
        for (int i = 0; i < 3; i++) begin
            bresp = (i == 1) ? 2'b10 : 2'b00;
            bvalid = 1;
            step();
            bvalid = 0;
            bresp = 2'b00;
            step();
            chk("wr_err_after_b", wr_err, i >= 1);
        end
        chk("err_dok", n_dok - dok0, 3);
        reset = 1'b1;
        #1;
        flush_model();
        chk("wr_err_rst", wr_err, 0);
        step();
        reset = 1'b0;
        step();
`endif

        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
